// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin share of one AXI read port, grant held from AR accept to rlast
module axi_read_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int GW            = $clog2(NUM_MASTERS)
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]           m_arlen,
  input  logic [NUM_MASTERS*3-1:0]           m_arsize,
  input  logic [NUM_MASTERS*2-1:0]           m_arburst,
  input  logic [NUM_MASTERS-1:0]             m_arvalid,
  output logic [NUM_MASTERS-1:0]             m_arready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_rdata,
  output logic [NUM_MASTERS*2-1:0]           m_rresp,
  output logic [NUM_MASTERS-1:0]             m_rlast,
  output logic [NUM_MASTERS-1:0]             m_rvalid,
  input  logic [NUM_MASTERS-1:0]             m_rready,
  output logic [ADDRESS_WIDTH-1:0]           s_araddr,
  output logic [7:0]                         s_arlen,
  output logic [2:0]                         s_arsize,
  output logic [1:0]                         s_arburst,
  output logic                               s_arvalid,
  input  logic                               s_arready,
  input  logic [DATA_WIDTH-1:0]              s_rdata,
  input  logic [1:0]                         s_rresp,
  input  logic                               s_rlast,
  input  logic                               s_rvalid,
  output logic                               s_rready,
  output logic [GW-1:0]                      grant,
  output logic                               busy,
  output logic                               len_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, state_n;
  logic [GW-1:0] grant_n, last_grant, last_grant_n, pick, idx;
  logic [8:0] beats_left, beats_left_n;
  logic len_err_n, arv_g, rr_g, addr_st, data_st;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      beats_left <= '0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      beats_left <= beats_left_n;
      len_err    <= len_err_n;
    end
  // scan from farthest to nearest so the master right after last_grant wins
  always_comb begin
    pick = grant;
    idx  = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NUM_MASTERS);
      if (m_arvalid[idx]) pick = idx;
    end
  end
  always_comb begin
    addr_st   = state == ADDR;
    data_st   = state == DATA;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    arv_g     = 1'b0;
    rr_g      = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (GW'(i) == grant) begin
        s_araddr  = m_araddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        s_arlen   = m_arlen[i*8 +: 8];
        s_arsize  = m_arsize[i*3 +: 3];
        s_arburst = m_arburst[i*2 +: 2];
        arv_g     = m_arvalid[i];
        rr_g      = m_rready[i];
        m_arready[i] = addr_st && s_arready;
        m_rvalid[i]  = data_st && s_rvalid;
        m_rlast[i]   = data_st && s_rlast;
        m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = data_st ? s_rdata : '0;
        m_rresp[i*2 +: 2] = data_st ? s_rresp : 2'b00;
      end
    s_arvalid = addr_st && arv_g;
    s_rready  = data_st && rr_g;
    busy      = state != IDLE;
  end
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    beats_left_n = beats_left;
    len_err_n    = len_err;
    if (state == IDLE && |m_arvalid) begin
      grant_n = pick;
      state_n = ADDR;
    end
    if (s_arvalid && s_arready) begin
      beats_left_n = {1'b0, s_arlen} + 9'd1;
      state_n      = DATA;
    end
    // rlast must land exactly on the final counted beat, in either direction
    if (s_rvalid && s_rready) begin
      beats_left_n = beats_left == '0 ? '0 : beats_left - 9'd1;
      len_err_n    = len_err | ((beats_left == 9'd1) != s_rlast);
      if (s_rlast) begin
        last_grant_n = grant;
        state_n      = IDLE;
      end
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed bench for axi_read_arbiter with a simple slave model
module tb_axi_read_arbiter;
  logic        aclk, aresetn;
  logic [15:0] m_araddr, m_arlen;
  logic [5:0]  m_arsize;
  logic [3:0]  m_arburst;
  logic [1:0]  m_arvalid, m_arready, m_rresp, m_rlast, m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [7:0]  s_araddr, s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic        grant, busy, len_err;
  int vec_cnt = 0, miss_cnt = 0, cyc = 0, rv0 = 0;
  int sl_beat, sl_len, early = 0;
  logic sl_active;
  logic [7:0] sl_addr;
  logic [32:0] rx0[$], rx1[$];
  logic gq[$];
  int acyc[$], lcyc[$];

  axi_read_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  assign s_rresp = 2'b00;

  // slave: word k of a burst at addr is 0xA000+addr+k; early>0 forces rlast on that beat
  always @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      sl_active <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_rdata <= '0;
      sl_beat <= 0; sl_len <= 0; sl_addr <= '0;
    end else if (!sl_active) begin
      if (s_arvalid && s_arready) begin
        sl_active <= 1'b1; sl_len <= int'(s_arlen); sl_addr <= s_araddr; sl_beat <= 0;
        s_rvalid <= 1'b1; s_rdata <= 32'hA000 + 32'(s_araddr);
        s_rlast <= s_arlen == 8'd0 || early == 1;
      end
    end else if (s_rready) begin
      if (s_rlast) begin
        sl_active <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0;
      end else begin
        sl_beat <= sl_beat + 1;
        s_rdata <= 32'hA000 + 32'(sl_addr) + 32'(sl_beat + 1);
        s_rlast <= sl_beat + 1 == sl_len || sl_beat + 2 == early;
      end
    end

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    rv0 <= rv0 + int'(m_rvalid[0]);
    if (s_arvalid && s_arready) begin gq.push_back(grant); acyc.push_back(cyc); end
    if (s_rvalid && s_rready && s_rlast) lcyc.push_back(cyc);
    if (m_rvalid[0] && m_rready[0]) rx0.push_back({m_rlast[0], m_rdata[31:0]});
    if (m_rvalid[1] && m_rready[1]) rx1.push_back({m_rlast[1], m_rdata[63:32]});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input int m, input logic [7:0] addr, input logic [7:0] len);
    int b;
    b = gq.size();
    @(negedge aclk);
    m_araddr[m*8 +: 8] = addr;
    m_arlen[m*8 +: 8] = len;
    m_arvalid[m] = 1'b1;
    for (int i = 0; i < 50 && gq.size() == b; i++) begin @(posedge aclk); #1; end
    m_arvalid[m] = 1'b0;
    chk("ar_accept", 64'(gq.size()), 64'(b + 1));
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) begin @(posedge aclk); #1; end
    chk(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, bg, bl, r0;
    aresetn = 1'b0; m_araddr = '0; m_arlen = '0; m_arsize = {3'd2, 3'd2}; m_arburst = {2'b01, 2'b01};
    m_arvalid = '0; m_rready = 2'b11; s_arready = 1'b1;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      chk("reset_idle", {m_arready, s_arvalid, busy, grant, len_err}, 0);
    end

    // master 1 alone, four-beat burst
    b1 = rx1.size(); r0 = rv0;
    @(negedge aclk);
    m_araddr[15:8] = 8'h40; m_arlen[15:8] = 8'd3; m_arvalid[1] = 1'b1;
    #1 chk("no_comb_ar", {s_arvalid, m_arready}, 0);
    @(posedge aclk); #1;
    chk("ar_valid", s_arvalid, 1);
    chk("ar_addr", s_araddr, 8'h40);
    chk("ar_len", s_arlen, 3);
    chk("grant_m1", grant, 1);
    chk("arready_m1", m_arready, 2'b10);
    @(posedge aclk); #1;
    m_arvalid[1] = 1'b0;
    for (int i = 0; i < 100 && rx1.size() < b1 + 4; i++) begin @(posedge aclk); #1; end
    chk("m1_beats", 64'(rx1.size() - b1), 4);
    for (int k = 0; k < 4; k++) chk("m1_data", rx1[b1 + k], {k == 3, 32'hA040 + 32'(k)});
    wait_idle("m1_done");
    chk("m0_rvalid_quiet", 64'(rv0 - r0), 0);
    chk("m1_len_err", len_err, 0);

    // both masters request continuously, single-beat bursts
    bg = gq.size(); bl = lcyc.size(); b1 = rx1.size();
    @(negedge aclk);
    m_araddr = {8'h80, 8'h00}; m_arlen = '0; m_arvalid = 2'b11;
    for (int i = 0; i < 100 && gq.size() < bg + 4; i++) begin @(posedge aclk); #1; end
    m_arvalid = 2'b00;
    wait_idle("rr_done");
    chk("rr_count", 64'(gq.size() - bg), 4);
    for (int k = 0; k < 4; k++) chk("rr_grant", gq[bg + k], k % 2);
    for (int k = 0; k < 3; k++) chk("rr_gap", 64'(acyc[bg + k + 1] - lcyc[bl + k]), 2);
    chk("rr_m1_data", rx1[rx1.size() - 1], {1'b1, 32'hA080});

    // master 0 stalls its R channel after three beats
    b0 = rx0.size();
    start(0, 8'h10, 8'd7);
    for (int i = 0; i < 100 && rx0.size() < b0 + 3; i++) begin @(posedge aclk); #1; end
    m_rready[0] = 1'b0;
    #1;
    chk("stall_rready", s_rready, 0);
    chk("stall_rvalid", m_rvalid[0], 1);
    chk("stall_data", m_rdata[31:0], 32'hA013);
    chk("stall_beats", dut.beats_left, 5);
    repeat (3) @(posedge aclk);
    #1;
    chk("stall_count", 64'(rx0.size() - b0), 3);
    chk("stall_hold", s_rdata, 32'hA013);
    chk("stall_beats2", dut.beats_left, 5);
    @(negedge aclk);
    m_rready[0] = 1'b1;
    for (int i = 0; i < 100 && rx0.size() < b0 + 8; i++) begin @(posedge aclk); #1; end
    chk("stall_total", 64'(rx0.size() - b0), 8);
    for (int k = 0; k < 8; k++) chk("stall_order", rx0[b0 + k], {k == 7, 32'hA010 + 32'(k)});
    wait_idle("stall_done");

    // slave ends an arlen=3 burst on beat 2
    b0 = rx0.size();
    early = 2;
    start(0, 8'h20, 8'd3);
    for (int i = 0; i < 100 && rx0.size() < b0 + 2; i++) begin @(posedge aclk); #1; end
    chk("early_idle", busy, 0);
    chk("early_err", len_err, 1);
    chk("early_last", rx0[b0 + 1], {1'b1, 32'hA021});
    early = 0;
    repeat (5) @(posedge aclk);
    #1 chk("err_sticky", len_err, 1);

    // reset in the middle of a burst, then priority restarts at master 0
    b0 = rx0.size();
    start(0, 8'h30, 8'd3);
    for (int i = 0; i < 100 && rx0.size() < b0 + 1; i++) begin @(posedge aclk); #1; end
    aresetn = 1'b0;
    #1;
    chk("rst_outputs", {m_rvalid, m_rlast, m_arready, s_arvalid, s_rready, busy}, 0);
    chk("rst_err", len_err, 0);
    chk("rst_grant", grant, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    m_arlen = '0; m_arvalid = 2'b11;
    @(posedge aclk); #1;
    chk("rst_prio_grant", grant, 0);
    chk("rst_prio_ar", s_arvalid, 1);
    @(posedge aclk); #1;
    m_arvalid = 2'b00;
    wait_idle("rst_done");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read port (AR + R channels) of the slave RAM among NUM_MASTERS requesters.
- Round-robin grant is locked for a whole burst, from AR acceptance until the R beat carrying rlast completes, so the slave needs no ID routing.
- Sits between the master-side interconnect and axi_slave_ram's read port.
- Also checks that the slave's rlast placement matches the granted arlen.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- DATA_WIDTH, 32, read data width in bits.
- ADDRESS_WIDTH, 8, byte address width.
- GW, $clog2(NUM_MASTERS), grant index width (derived; do not override).

Ports:
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- m_araddr  in  NUM_MASTERS*ADDRESS_WIDTH  packed per-master AR address; master i at slice i.
- m_arlen  in  NUM_MASTERS*8  per-master burst length minus 1.
- m_arsize  in  NUM_MASTERS*3  per-master beat size.
- m_arburst  in  NUM_MASTERS*2  per-master burst type.
- m_arvalid  in  NUM_MASTERS  per-master AR valid.
- m_arready  out  NUM_MASTERS  per-master AR ready.
- m_rdata  out  NUM_MASTERS*DATA_WIDTH  per-master read data.
- m_rresp  out  NUM_MASTERS*2  per-master read response.
- m_rlast  out  NUM_MASTERS  per-master last beat.
- m_rvalid  out  NUM_MASTERS  per-master R valid.
- m_rready  in  NUM_MASTERS  per-master R ready.
- s_araddr, s_arlen, s_arsize, s_arburst  out  ADDRESS_WIDTH/8/3/2  AR fields to slave.
- s_arvalid  out  1  AR valid to slave.
- s_arready  in  1  AR ready from slave.
- s_rdata  in  DATA_WIDTH  read data from slave.
- s_rresp  in  2  read response from slave.
- s_rlast  in  1  last beat from slave.
- s_rvalid  in  1  R valid from slave.
- s_rready  out  1  R ready to slave.
- grant  out  GW  index of the currently owning master.
- busy  out  1  high in ADDR and DATA states.
- len_err  out  1  sticky flag: rlast position mismatched arlen.

Behaviour:
- States: IDLE, ADDR, DATA. Registers: state, grant, last_grant, beats_left[8:0], len_err.
- Reset (aresetn low, asynchronous, applies at any time including mid-burst):
  - state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (master 0 has first priority), beats_left=0, len_err=0.
  - All outputs deasserted: s_arvalid=0, s_rready=0, m_arready=0, m_rvalid=0, m_rlast=0, busy=0.
  - Any in-flight slave burst is abandoned.
- IDLE:
  - No m_arready asserted; s_arvalid=0.
  - If any m_arvalid is high, grant <= first requester scanning last_grant+1, +2, … modulo NUM_MASTERS; go to ADDR.
  - Decision is registered: a request first seen in cycle N gives s_arvalid high in cycle N+1.
- ADDR:
  - s_ar* fields and s_arvalid are combinationally muxed from master[grant].
  - m_arready[grant] = s_arready; all other m_arready bits are 0.
  - On s_arvalid && s_arready: beats_left <= {1'b0, arlen[grant]} + 1; go to DATA.
  - If the granted master drops arvalid (AXI violation), remain in ADDR and do not regrant.
- DATA:
  - m_rdata/m_rresp/m_rlast/m_rvalid of master[grant] follow the slave combinationally; other masters see rvalid=0, rlast=0, and rdata/rresp=0.
  - s_rready = m_rready[grant].
  - Each s_rvalid && s_rready beat decrements beats_left.
  - Beat with s_rlast=1: last_grant <= grant; go to IDLE. If beats_left != 1 at that beat, set len_err.
  - Beat with beats_left==1 and s_rlast=0: set len_err; stay in DATA until rlast arrives.
  - beats_left saturates at 0 and never wraps.
- Zero-combinational paths: m_arvalid does not reach any m_arready in the same cycle except through the registered grant. This removes any arvalid-to-arready loop.
- Simultaneous requests: round-robin order only. A master that just completed has the lowest priority next.
- Requests arriving during ADDR or DATA wait; a pending m_arvalid is held by the master per AXI.
- Back-to-back bursts have one IDLE bubble cycle between the rlast beat and the next s_arvalid.
- busy = (state != IDLE).

Test Plan:
- Reset, then no requests -> all m_arready=0, s_arvalid=0, busy=0, grant=0, len_err=0 for 10 cycles.
- Master 1 alone, arlen=3, araddr=0x40 -> s_arvalid one cycle after m_arvalid[1], s_araddr=0x40. Exactly 4 beats delivered to master 1 with rlast on the 4th; m_rvalid[0] stays 0; len_err=0.
- Masters 0 and 1 both request continuously, arlen=0 -> grants alternate 0,1,0,1 over 4 bursts, with a 1-cycle IDLE gap between each.
- Master 0 deasserts m_rready mid-burst (arlen=7) -> s_rready low, slave holds beat 3, beats_left unchanged. The burst completes after m_rready returns, with all 8 data words in order.
- Slave model asserts rlast on beat 2 of an arlen=3 burst -> arbiter returns to IDLE and len_err=1, sticky until aresetn.
- aresetn pulsed low during DATA beat 2 -> outputs go low immediately. After release, the next request from master 1 while master 0 also requests is granted to master 0.
